// File: rtl/scv_clk_timing_gen.sv
// -----------------------------------------------------------------------------
// scv_clk_timing_gen
//
// Clock/timing generator for the uPD7800 core. Two independent blocks:
//
//   1. Phase sequencer: walks S0 -> S1 -> S2 -> S3 -> S0, each slot lasting
//      PHASE_DIV CLK cycles. It emits a one-CLK strobe at the start of every
//      slot and CP1/CP2 levels. HOLD freezes the sequencer for bus wait states
//      without losing or duplicating any strobe.
//   2. VBL timer: free-running two-segment timer (idle / active). It ignores
//      HOLD and drives the INT2 level plus a FRAME_START strobe on each rise.
//
// Ports:
//   CLK            in   core clock
//   RES            in   synchronous, active-high reset
//   HOLD           in   1 = freeze phase sequencer
//   VBL_IDLE_LEN   in   CLK cycles with VBL=0 per frame (0 behaves as 1)
//   VBL_ACTIVE_LEN in   CLK cycles with VBL=1 per frame (0 behaves as 1)
//   CP1_POSEDGE    out  strobe, start of S0
//   CP1_NEGEDGE    out  strobe, start of S1
//   CP2_POSEDGE    out  strobe, start of S2
//   CP2_NEGEDGE    out  strobe, start of S3
//   CP1            out  level, 1 during S0
//   CP2            out  level, 1 during S2
//   VBL            out  vertical-blank level (upd7800 INT2)
//   FRAME_START    out  strobe coincident with VBL rising
//
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module scv_clk_timing_gen #(
   parameter int PHASE_DIV = 1,
   parameter int CW        = 20
) (
   input  logic          CLK,
   input  logic          RES,
   input  logic          HOLD,
   input  logic [CW-1:0] VBL_IDLE_LEN,
   input  logic [CW-1:0] VBL_ACTIVE_LEN,
   output logic          CP1_POSEDGE,
   output logic          CP1_NEGEDGE,
   output logic          CP2_POSEDGE,
   output logic          CP2_NEGEDGE,
   output logic          CP1,
   output logic          CP2,
   output logic          VBL,
   output logic          FRAME_START
);

   localparam int DW = (PHASE_DIV > 1) ? $clog2(PHASE_DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(PHASE_DIV - 1);

   // Phase slot encoding
   localparam logic [1:0] S0 = 2'd0;
   localparam logic [1:0] S1 = 2'd1;
   localparam logic [1:0] S2 = 2'd2;
   localparam logic [1:0] S3 = 2'd3;

   // A zero length would make seg_len-1 wrap; treat it as a 1-CLK segment.
   function automatic logic [CW-1:0] len_fix(input logic [CW-1:0] v);
      return (v == '0) ? CW'(1) : v;
   endfunction

   // ---------------------------------------------------------------------------
   // Phase sequencer
   // ---------------------------------------------------------------------------
   logic [1:0]    slot_q,   slot_d;
   logic [DW-1:0] divcnt_q, divcnt_d;
   // strobe bit i fires on entry to slot i: [0]=CP1 pos, [1]=CP1 neg,
   // [2]=CP2 pos, [3]=CP2 neg
   logic [3:0]    strobe_q, strobe_d;
   logic          cp1_q,    cp1_d;
   logic          cp2_q,    cp2_d;

   always_comb begin
      slot_d   = slot_q;
      divcnt_d = divcnt_q;
      strobe_d = 4'b0000;
      if (!HOLD) begin
         if (divcnt_q == DIV_LAST) begin
            divcnt_d = '0;
            slot_d   = slot_q + 2'd1;
            strobe_d = 4'b0001 << slot_d;
         end else begin
            divcnt_d = divcnt_q + DW'(1);
         end
      end
      // Levels follow the slot register, so they simply hold while frozen.
      cp1_d = (slot_d == S0);
      cp2_d = (slot_d == S2);
   end

   // ---------------------------------------------------------------------------
   // VBL timer
   // ---------------------------------------------------------------------------
   logic [CW-1:0] vcnt_q,   vcnt_d;
   logic [CW-1:0] seg_len_q, seg_len_d;
   logic          vbl_q,    vbl_d;
   logic          fs_q,     fs_d;

   always_comb begin
      vcnt_d    = vcnt_q + CW'(1);
      seg_len_d = seg_len_q;
      vbl_d     = vbl_q;
      fs_d      = 1'b0;
      // seg_len_q is never 0, so seg_len_q-1 cannot wrap.
      if (vcnt_q == seg_len_q - CW'(1)) begin
         vcnt_d    = '0;
         vbl_d     = ~vbl_q;
         // Lengths are only sampled here, so mid-segment edits wait for the
         // next segment of the matching kind.
         seg_len_d = vbl_d ? len_fix(VBL_ACTIVE_LEN) : len_fix(VBL_IDLE_LEN);
         fs_d      = vbl_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (RES) begin
         // S3 with a full divider means the first free edge enters S0.
         slot_q    <= S3;
         divcnt_q  <= DIV_LAST;
         strobe_q  <= 4'b0000;
         cp1_q     <= 1'b0;
         cp2_q     <= 1'b0;
         vcnt_q    <= '0;
         seg_len_q <= len_fix(VBL_IDLE_LEN);
         vbl_q     <= 1'b0;
         fs_q      <= 1'b0;
      end else begin
         slot_q    <= slot_d;
         divcnt_q  <= divcnt_d;
         strobe_q  <= strobe_d;
         cp1_q     <= cp1_d;
         cp2_q     <= cp2_d;
         vcnt_q    <= vcnt_d;
         seg_len_q <= seg_len_d;
         vbl_q     <= vbl_d;
         fs_q      <= fs_d;
      end
   end

   assign CP1_POSEDGE = strobe_q[0];
   assign CP1_NEGEDGE = strobe_q[1];
   assign CP2_POSEDGE = strobe_q[2];
   assign CP2_NEGEDGE = strobe_q[3];
   assign CP1         = cp1_q;
   assign CP2         = cp2_q;
   assign VBL         = vbl_q;
   assign FRAME_START = fs_q;

endmodule
